// File: rtl/i_type_encoder.sv
// i_type_encoder: streaming RV32I I-type encoder emitting {imm, rs1, funct3, rd, opcode} with sequential byte addresses
// Ports: clk, rst_n (async active-low), clear (sync restart);
//   in_valid/in_ready + opcode, rd, rs1, funct3, imm: field input handshake;
//   out_valid/out_ready + out_instr, out_addr: single-stage output register;
//   full: DEPTH legal words accepted; err/err_count: illegal-input pulse and saturating count.
// Define ITYPE_LEGALITY_CHECK_EN to reject non-I-type opcodes and malformed funct3/imm combinations.
module i_type_encoder #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       DEPTH     = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [2:0]        funct3,
    input  logic [11:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              full,
    output logic              err,
    output logic [7:0]        err_count
);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] addr_q, addr_d, out_addr_q, out_addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       instr_q, instr_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic              full_q, full_d, out_valid_q, out_valid_d, err_q, err_d;
    logic              xfer, illegal, load;

    assign in_ready = !full_q && (!out_valid_q || out_ready);
    assign xfer     = in_valid && in_ready;

`ifdef ITYPE_LEGALITY_CHECK_EN
    logic is_load, is_opimm, is_jalr;
    assign is_load  = opcode == 7'b0000011;
    assign is_opimm = opcode == 7'b0010011;
    assign is_jalr  = opcode == 7'b1100111;
    // Shift-immediates carry funct7 in imm[11:5]; only SRAI may set bit 10 (0100000).
    assign illegal  = !(is_load || is_opimm || is_jalr)
                   || (is_load && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111))
                   || (is_jalr && funct3 != 3'b000)
                   || (is_opimm && funct3 == 3'b001 && imm[11:5] != 7'b0000000)
                   || (is_opimm && funct3 == 3'b101 && imm[11:5] != 7'b0000000 && imm[11:5] != 7'b0100000);
`else
    assign illegal = 1'b0;
`endif

    assign load = xfer && !illegal;

    // clear wins over any simultaneous transfer, which is discarded.
    always_comb begin
        addr_d      = clear ? BASE_ADDR : load ? addr_q + ADDR_W'(4) : addr_q;
        cnt_d       = clear ? '0 : load ? cnt_q + CNT_W'(1) : cnt_q;
        full_d      = !clear && (full_q || (load && cnt_q == CNT_W'(DEPTH - 1)));
        out_valid_d = !clear && (load || (out_valid_q && !out_ready));
        instr_d     = clear ? '0 : load ? {imm, rs1, funct3, rd, opcode} : instr_q;
        out_addr_d  = clear ? BASE_ADDR : load ? addr_q : out_addr_q;
        err_d       = !clear && xfer && illegal;
        err_cnt_d   = clear ? '0 : (err_d && err_cnt_q != 8'hff) ? err_cnt_q + 8'd1 : err_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= BASE_ADDR;
            cnt_q       <= '0;
            full_q      <= 1'b0;
            out_valid_q <= 1'b0;
            instr_q     <= '0;
            out_addr_q  <= BASE_ADDR;
            err_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            instr_q     <= instr_d;
            out_addr_q  <= out_addr_d;
            err_q       <= err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_instr = instr_q;
    assign out_addr  = out_addr_q;
    assign full      = full_q;
    assign err       = err_q;
    assign err_count = err_cnt_q;
endmodule

// File: tb/tb_i_type_encoder.sv
// tb_i_type_encoder: randomized scoreboard bench for i_type_encoder with a field-level reference model
module tb_i_type_encoder;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'hFFFF_FFF8;
`ifdef ITYPE_LEGALITY_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk = 1'b0, rst_n = 1'b0, clear = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic [6:0]  opcode = '0;
    logic [4:0]  rd = '0, rs1 = '0;
    logic [2:0]  funct3 = '0;
    logic [11:0] imm = '0;
    logic        in_ready, out_valid, full, err;
    logic [31:0] out_instr, out_addr;
    logic [7:0]  err_count;

    i_type_encoder #(.ADDR_W(32), .BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .rd(rd), .rs1(rs1), .funct3(funct3), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
        .full(full), .err(err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    logic [63:0] sb[$];
    logic [31:0] m_addr;
    int          m_cnt, m_errc;
    bit          m_full, m_held, m_err_pend;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit legal(logic [6:0] op, logic [2:0] f, logic [11:0] im);
        bit ok;
        case (op)
            7'h03:   ok = !(f == 3'd3 || f == 3'd6 || f == 3'd7);
            7'h67:   ok = f == 3'd0;
            7'h13:   ok = f == 3'd1 ? im[11:5] == 7'h00 : f == 3'd5 ? (im[11:5] == 7'h00 || im[11:5] == 7'h20) : 1'b1;
            default: ok = 1'b0;
        endcase
        return CHK ? ok : 1'b1;
    endfunction

    function automatic logic [31:0] enc(logic [6:0] op, logic [4:0] d, logic [4:0] s, logic [2:0] f, logic [11:0] im);
        return 32'(im) * 32'h0010_0000 + 32'(s) * 32'h8000 + 32'(f) * 32'h1000 + 32'(d) * 32'h80 + 32'(op);
    endfunction

    task automatic model_reset();
        m_addr = BASE; m_cnt = 0; m_errc = 0; m_full = 0; m_held = 0; m_err_pend = 0;
        sb.delete();
    endtask

    // Runs just after the falling edge, once the monitor has taken any drained word.
    task automatic step();
        bit rdy, acc;
        rdy = !m_full && (!m_held || out_ready);
        chk("in_ready", 32'(in_ready), 32'(rdy));
        chk("full", 32'(full), 32'(m_full));
        chk("err", 32'(err), 32'(m_err_pend));
        chk("err_count", 32'(err_count), 32'(m_errc));
        m_err_pend = 0;
        if (clear) model_reset();
        else begin
            acc = in_valid && rdy;
            if (acc && legal(opcode, funct3, imm)) begin
                sb.push_back({enc(opcode, rd, rs1, funct3, imm), m_addr});
                m_addr = m_addr + 32'd4;
                m_cnt++;
                if (m_cnt == DEPTH) m_full = 1;
                m_held = 1;
            end else begin
                if (acc) begin
                    m_err_pend = 1;
                    if (m_errc < 255) m_errc++;
                end
                if (out_ready) m_held = 0;
            end
        end
    endtask

    task automatic cyc(bit v, logic [6:0] op, logic [4:0] d, logic [4:0] s, logic [2:0] f, logic [11:0] im, bit ordy, bit clr);
        in_valid = v; opcode = op; rd = d; rs1 = s; funct3 = f; imm = im; out_ready = ordy; clear = clr;
        @(negedge clk);
        #1 step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; clear = 0;
        rst_n = 0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        chk("rst_out_addr", out_addr, BASE);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    initial begin : monitor
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
                if (out_valid && out_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("out_instr", out_instr, e[63:32]);
                    chk("out_addr", out_addr, e[31:0]);
                end
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish, n_cmp %0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [31:0] held;
        logic [6:0]  op;
        model_reset();
        @(posedge clk);
        #1 do_reset();
        cyc(1, 7'h13, 5'd1, 5'd0, 3'd0, 12'h005, 1, 0);
        chk("addi_instr", out_instr, 32'h0050_0093);
        chk("addi_addr", out_addr, BASE);
        cyc(1, 7'h03, 5'd2, 5'd3, 3'd2, 12'hFFC, 1, 0);
        chk("lw_instr", out_instr, 32'hFFC1_A103);
        chk("lw_addr", out_addr, BASE + 32'd4);
        chk("rt_imm", {{20{out_instr[31]}}, out_instr[31:20]}, -32'sd4);
        chk("rt_rs1", 32'(out_instr[19:15]), 32'd3);
        chk("rt_f3", 32'(out_instr[14:12]), 32'd2);
        chk("rt_rd", 32'(out_instr[11:7]), 32'd2);
        chk("rt_op", 32'(out_instr[6:0]), 32'h03);
        held = out_instr;
        for (int i = 0; i < 5; i++) begin
            cyc(1, 7'h13, 5'd4, 5'd5, 3'd0, 12'h00A, 0, 0);
            chk("bp_stable", out_instr, held);
        end
        cyc(1, 7'h13, 5'd4, 5'd5, 3'd0, 12'h00A, 1, 0);
        cyc(1, 7'h13, 5'd6, 5'd7, 3'd4, 12'h7FF, 1, 0);
        cyc(0, 7'h00, 5'd0, 5'd0, 3'd0, 12'h000, 1, 1);
        cyc(1, 7'h13, 5'd0, 5'd0, 3'd1, 12'h420, 1, 0);
        cyc(1, 7'h67, 5'd1, 5'd2, 3'd0, 12'h010, 1, 0);
        cyc(0, 7'h00, 5'd0, 5'd0, 3'd0, 12'h000, 1, 0);
        cyc(0, 7'h00, 5'd0, 5'd0, 3'd0, 12'h000, 1, 1);
        for (int i = 0; i < 6; i++) cyc(1, 7'h13, 5'(i), 5'(i + 1), 3'd0, 12'(i), 1, 0);
        cyc(1, 7'h13, 5'd9, 5'd9, 3'd0, 12'h001, 1, 0);
        cyc(0, 7'h00, 5'd0, 5'd0, 3'd0, 12'h000, 1, 1);
        cyc(1, 7'h03, 5'd8, 5'd9, 3'd0, 12'h123, 1, 0);
        chk("clear_addr", out_addr, BASE);
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 350) do_reset();
            else begin
                case ($urandom_range(0, 4))
                    0:       op = 7'h03;
                    1:       op = 7'h67;
                    2, 3:    op = 7'h13;
                    default: op = 7'($urandom);
                endcase
                cyc($urandom_range(0, 3) != 0, op, 5'($urandom), 5'($urandom), 3'($urandom),
                    $urandom_range(0, 1) ? 12'($urandom) : {($urandom_range(0, 1) ? 7'h20 : 7'h00), 5'($urandom)},
                    $urandom_range(0, 3) != 0, $urandom_range(0, 30) == 0);
            end
        end
        for (int i = 0; i < 3; i++) cyc(0, 7'h00, 5'd0, 5'd0, 3'd0, 12'h000, 1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
